// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional encoder.
// K = constraint length, G0_DEF/G1_DEF = default generator polynomials
// (bit K-1 taps the newest input), enc_state_t = encoder frame FSM states.
package viterbi_pkg;

    localparam int unsigned K      = 3;
    localparam int unsigned SREG_W = K - 1;
    localparam int unsigned PAIR_W = 2;

    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2 parity core.
// Ports:
//   u        - information bit entering the register
//   s        - current shift state, s[1] = most recent bit
//   pair_c   - {G0 parity, G1 parity} for r = {u, s}
//   s_next_c - shift state after u is shifted in
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic              u,
    input  logic [SREG_W-1:0] s,
    output logic [PAIR_W-1:0] pair_c,
    output logic [SREG_W-1:0] s_next_c
);

    logic [K-1:0] r;

    assign r        = {u, s};
    assign pair_c   = {^(r & G0), ^(r & G1)};
    // Drop the oldest bit; u becomes the new s[1].
    assign s_next_c = r[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready handshakes on both
// sides, a one-entry output register and a per-frame pair counter.
// Build option: define CONV_ENCODER_TAIL_EN to flush two zero tail bits after
// the last data bit; otherwise the last data pair ends the frame directly.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_bit/in_valid/in_last - information bit input, in_ready = accept
//   tx_pair/out_valid/out_last - coded pair output, out_ready = downstream accept
//   pair_cnt                - pairs emitted in the current frame (saturating)
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0    = G0_DEF,
    parameter logic [K-1:0] G1    = G1_DEF,
    parameter int unsigned  CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [PAIR_W-1:0] tx_pair,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pair_cnt
);

    enc_state_t        state_q, state_d;
    logic [SREG_W-1:0] s_q, s_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic              ov_q, ov_d;
    logic              ol_q, ol_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef CONV_ENCODER_TAIL_EN
    logic              tail_q, tail_d;   // 0: first tail pair next, 1: second
`endif

    logic              slot_free;
    logic              in_xfer;
    logic              core_u;
    logic [PAIR_W-1:0] core_pair;
    logic [SREG_W-1:0] core_s_next;
    logic [CNT_W-1:0]  cnt_inc;

    // Tail pairs always shift in zeros.
    assign core_u = (state_q == TAIL) ? 1'b0 : in_bit;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u        (core_u),
        .s        (s_q),
        .pair_c   (core_pair),
        .s_next_c (core_s_next)
    );

    assign slot_free = !ov_q || out_ready;
    assign in_ready  = slot_free && (state_q != TAIL);
    assign in_xfer   = in_valid && in_ready;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        pair_d  = pair_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        cnt_d   = cnt_q;
`ifdef CONV_ENCODER_TAIL_EN
        tail_d  = tail_q;
`endif

        // Pair consumed; a load below overrides this.
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end

        unique case (state_q)
            IDLE, DATA: begin
                if (in_xfer) begin
                    pair_d = core_pair;
                    ov_d   = 1'b1;
                    cnt_d  = (state_q == IDLE) ? CNT_W'(1) : cnt_inc;
                    s_d    = core_s_next;
                    ol_d   = 1'b0;
                    if (in_last) begin
`ifdef CONV_ENCODER_TAIL_EN
                        state_d = TAIL;
                        tail_d  = 1'b0;
`else
                        ol_d    = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
`ifdef CONV_ENCODER_TAIL_EN
            TAIL: begin
                if (slot_free) begin
                    pair_d = core_pair;
                    ov_d   = 1'b1;
                    cnt_d  = cnt_inc;
                    s_d    = core_s_next;
                    if (tail_q) begin
                        ol_d    = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        ol_d    = 1'b0;
                        tail_d  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            pair_q  <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef CONV_ENCODER_TAIL_EN
            tail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            pair_q  <= pair_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            cnt_q   <= cnt_d;
`ifdef CONV_ENCODER_TAIL_EN
            tail_q  <= tail_d;
`endif
        end
    end

    assign tx_pair   = pair_q;
    assign out_valid = ov_q;
    assign out_last  = ol_q;
    assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Table-driven bench for conv_encoder. Each row drives one cycle of inputs
// at the falling edge and checks the outputs visible during that cycle.
// Expectations follow the build: CONV_ENCODER_TAIL_EN selects the tail table.
module tb_conv_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_bit;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [1:0]  tx_pair;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] pair_cnt;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        ib;
        logic        il;
        logic        ordy;
        logic        eov;
        logic [1:0]  ep;
        logic        el;
        logic [15:0] ecnt;
        logic        erdy;
        logic        full;   // check pair/last/cnt even when out_valid=0
    } vec_t;

    vec_t tbl[$];

    conv_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .tx_pair   (tx_pair),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .pair_cnt  (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic iv, input logic ib,
                                input logic il, input logic ordy, input logic eov,
                                input logic [1:0] ep, input logic el,
                                input logic [15:0] ecnt, input logic erdy,
                                input logic full);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ib = ib; v.il = il; v.ordy = ordy;
        v.eov = eov; v.ep = ep; v.el = el; v.ecnt = ecnt; v.erdy = erdy;
        v.full = full;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n     = tbl[i].rst;
            in_valid  = tbl[i].iv;
            in_bit    = tbl[i].ib;
            in_last   = tbl[i].il;
            out_ready = tbl[i].ordy;
            #1;
            chk("out_valid", i, 32'(out_valid), 32'(tbl[i].eov));
            chk("in_ready", i, 32'(in_ready), 32'(tbl[i].erdy));
            if (tbl[i].eov || tbl[i].full) begin
                chk("tx_pair", i, 32'(tx_pair), 32'(tbl[i].ep));
                chk("out_last", i, 32'(out_last), 32'(tbl[i].el));
                chk("pair_cnt", i, 32'(pair_cnt), 32'(tbl[i].ecnt));
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // cols: rst iv ib il ordy | ov pair last cnt rdy full
`ifdef CONV_ENCODER_TAIL_EN
        // frame 1,0,1,1 with two tail pairs; input during TAIL is ignored
        add(1,1,1,0,1, 0,2'b00,0,0,1,1);
        add(1,1,0,0,1, 1,2'b11,0,1,1,0);
        add(1,1,1,0,1, 1,2'b10,0,2,1,0);
        add(1,1,1,1,1, 1,2'b00,0,3,1,0);
        add(1,1,1,0,1, 1,2'b01,0,4,0,0);
        add(1,0,0,0,1, 1,2'b01,0,5,0,0);
        add(1,0,0,0,1, 1,2'b11,1,6,1,0);
        // single-bit frame -> 3 pairs
        add(1,1,1,1,1, 0,2'b00,0,0,1,0);
        add(1,0,0,0,1, 1,2'b11,0,1,0,0);
        add(1,0,0,0,1, 1,2'b10,0,2,0,0);
        add(1,0,0,0,1, 1,2'b11,1,3,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
        // frame 1,0,1,1 with 3-cycle stall after the 2nd pair
        add(1,1,1,0,1, 0,2'b00,0,0,1,0);
        add(1,1,0,0,1, 1,2'b11,0,1,1,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,1,0,1, 1,2'b10,0,2,1,0);
        add(1,1,1,1,1, 1,2'b00,0,3,1,0);
        add(1,0,0,0,1, 1,2'b01,0,4,0,0);
        add(1,0,0,0,1, 1,2'b01,0,5,0,0);
        add(1,0,0,0,1, 1,2'b11,1,6,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
        // reset during the first tail pair, then a fresh frame from s=0
        add(1,1,1,1,1, 0,2'b00,0,0,1,0);
        add(1,0,0,0,1, 1,2'b11,0,1,0,0);
        add(0,0,0,0,1, 1,2'b10,0,2,0,0);
        add(1,1,1,1,1, 0,2'b00,0,0,1,1);
        add(1,0,0,0,1, 1,2'b11,0,1,0,0);
        add(1,0,0,0,1, 1,2'b10,0,2,0,0);
        add(1,0,0,0,1, 1,2'b11,1,3,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
`else
        // frame 1,0,1,1 ends on its own last pair; next frame starts at s=0
        add(1,1,1,0,1, 0,2'b00,0,0,1,1);
        add(1,1,0,0,1, 1,2'b11,0,1,1,0);
        add(1,1,1,0,1, 1,2'b10,0,2,1,0);
        add(1,1,1,1,1, 1,2'b00,0,3,1,0);
        add(1,0,0,0,1, 1,2'b01,1,4,1,0);
        add(1,1,1,1,1, 0,2'b00,0,0,1,0);
        add(1,0,0,0,1, 1,2'b11,1,1,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
        // frame 1,0,1,1 with 3-cycle stall; stalled input must be ignored
        add(1,1,1,0,1, 0,2'b00,0,0,1,0);
        add(1,1,0,0,1, 1,2'b11,0,1,1,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,0,0,0, 1,2'b10,0,2,0,0);
        add(1,1,1,0,1, 1,2'b10,0,2,1,0);
        add(1,1,1,1,1, 1,2'b00,0,3,1,0);
        add(1,0,0,0,1, 1,2'b01,1,4,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
        // reset mid-frame, then a single-bit frame from s=0
        add(1,1,1,0,1, 0,2'b00,0,0,1,0);
        add(1,1,0,0,1, 1,2'b11,0,1,1,0);
        add(0,0,0,0,1, 1,2'b10,0,2,1,0);
        add(1,1,1,1,1, 0,2'b00,0,0,1,1);
        add(1,0,0,0,1, 1,2'b11,1,1,1,0);
        add(1,0,0,0,1, 0,2'b00,0,0,1,0);
`endif

        run_tbl();

        // pair_cnt saturation on a long all-zero frame
        @(negedge clk);
        in_valid  = 1'b1;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (65540) @(negedge clk);
        in_last = 1'b1;
        #1;
        chk("sat_cnt", 0, 32'(pair_cnt), 32'h0000_ffff);
        chk("sat_valid", 0, 32'(out_valid), 32'd1);
        chk("sat_pair", 0, 32'(tx_pair), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("sat_cnt_last", 0, 32'(pair_cnt), 32'h0000_ffff);
        repeat (5) @(negedge clk);
        #1;
        chk("drain_valid", 0, 32'(out_valid), 32'd0);
        chk("drain_ready", 0, 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter G0, default 3'b111, generator polynomial for tx_pair[1], bit 2 taps the newest input.
REQ-002 Parameter G1, default 3'b101, generator polynomial for tx_pair[0], bit 2 taps the newest input.
REQ-003 Parameter CNT_W, default 16, width of the pair counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_bit  input  1  information bit.
REQ-007 in_valid  input  1  in_bit/in_last valid.
REQ-008 in_last  input  1  in_bit is the final data bit of the frame.
REQ-009 in_ready  output  1  encoder accepts input this cycle.
REQ-010 tx_pair  output  2  coded pair; [1]=G0 parity, [0]=G1 parity.
REQ-011 out_valid  output  1  tx_pair valid.
REQ-012 out_last  output  1  tx_pair is the final pair of the frame.
REQ-013 out_ready  input  1  downstream accepts tx_pair.
REQ-014 pair_cnt  output  CNT_W  pairs emitted in the current frame, including the one on tx_pair.

Function
REQ-015 Encoder SHALL be rate 1/2, K=3, with shift state s[1:0] where s[1] is the most recent bit.
REQ-016 For input u: r={u,s[1],s[0]}; tx_pair[1]=^(r&G0); tx_pair[0]=^(r&G1); next s={u,s[1]}.
REQ-017 Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
REQ-018 Output is a one-entry register: out_valid SHALL rise the cycle after an input transfer (latency 1).
REQ-019 in_ready SHALL be (!out_valid||out_ready) && state!=TAIL, which allows full throughput of one pair per cycle.
REQ-020 While out_valid&&!out_ready, tx_pair, out_last and pair_cnt SHALL hold stable.
REQ-021 FSM states: IDLE (s=0, no frame open), DATA (frame open), TAIL (flushing).
REQ-022 IDLE->DATA on an input transfer with in_last=0; IDLE/DATA->TAIL on an input transfer with in_last=1; DATA stays in DATA otherwise.
REQ-023 TAIL SHALL inject u=0 twice, each time the output slot frees, producing two tail pairs; the second pair has out_last=1, then the FSM goes to IDLE with s=0.
REQ-024 pair_cnt SHALL be 1 for the first pair of a frame, increment by 1 per loaded pair, and saturate at all-ones.
REQ-025 A single-bit frame (in_last on the first bit) SHALL yield exactly 3 pairs.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-027 When rst_n=0 at a clock edge: FSM=IDLE, s=0, out_valid=0, out_last=0, tx_pair=0, pair_cnt=0; in_ready SHALL be 1 the cycle after reset.
REQ-028 Reset mid-frame or mid-TAIL SHALL discard the pending pair and the remaining tail with no out_last emitted.

Configuration
REQ-029 Macro CONV_ENCODER_TAIL_EN defined: tail flush per REQ-023.
REQ-030 CONV_ENCODER_TAIL_EN undefined: no TAIL state; the in_last pair carries out_last=1, s is cleared to 0 after that transfer, and the FSM returns to IDLE.

Structure
REQ-031 Package viterbi_pkg SHALL hold the constants K=3, G0_DEF=3'b111, G1_DEF=3'b101 and the typedef enum enc_state_t {IDLE,DATA,TAIL}.
REQ-032 Sub-module conv_enc_core SHALL compute the combinational parity (u,s,G0,G1 -> pair,next s); the FSM, counter and handshake SHALL reside in conv_encoder.

Verification
REQ-033 Frame 1,0,1,1 (last on the 4th bit), out_ready=1, TAIL_EN -> tx_pair 11,10,00,01,01,11; out_last only on the 6th; pair_cnt 1..6.
REQ-034 Same frame with out_ready low for 3 cycles after the 2nd pair -> tx_pair=10 held, in_ready=0, identical final sequence.
REQ-035 Single bit 1 with in_last, TAIL_EN -> 11,10,11, out_last on the 3rd, then IDLE, in_ready=1.
REQ-036 rst_n=0 during the first tail pair -> next cycle out_valid=0, pair_cnt=0; a new frame 1 (last) encodes from s=0 as 11,10,11.
REQ-037 TAIL_EN undefined, frame 1,0,1,1 -> 11,10,00,01 with out_last on 01; a following frame starts from s=0.
